// File: rtl/fpu_mmio_queue.sv
// fpu_mmio_queue: MMIO front end that issues jobs to a start/done FP core and queues results plus flags.
module fpu_mmio_queue #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 6,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        a,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    output logic [DATA_W-1:0] rd,
    output logic              irq,
    output logic              invalid,
    output logic              overflow,
    output logic              core_start,
    output logic              core_op,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_p,
    input  logic [FLAG_W-1:0] core_flags
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_n;
    logic [DATA_W-1:0] opa, opb, status, head_p;
    logic [FLAG_W-1:0] head_f;
    logic op, irq_en, drop_err;
    logic [DATA_W-1:0] mem_p [DEPTH];
    logic [FLAG_W-1:0] mem_f [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CNT_W-1:0] count;
    logic empty, full, busy, start_req, accept, push, pop;
    assign empty     = count == '0;
    assign full      = count == CNT_W'(DEPTH);
    assign busy      = state != IDLE;
    assign start_req = we && a == 3'd2 && wd[0];
    assign accept    = start_req && !busy && !full;
    assign push      = core_done && busy;
    assign pop       = we && a == 3'd4 && !empty;
    assign head_p    = mem_p[rp];
    assign head_f    = mem_f[rp];
    assign irq       = irq_en && !empty;
    assign invalid   = !empty && (head_f[1] || head_f[0] || head_f[4]);
    assign overflow  = !empty && (head_f[5] || head_f[2]);
    // Next-state logic; the start pulse is simply the ISSUE state.
    always_comb begin
        state_n    = state;
        core_start = state == ISSUE;
        case (state)
            IDLE:    state_n = accept ? ISSUE : IDLE;
            ISSUE:   state_n = core_done ? IDLE : WAIT;
            WAIT:    state_n = core_done ? IDLE : WAIT;
            default: state_n = IDLE;
        endcase
    end
    // Control registers, operand snapshot, drop flag and FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            op       <= 1'b0;
            irq_en   <= 1'b0;
            drop_err <= 1'b0;
            core_a   <= '0;
            core_b   <= '0;
            core_op  <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
        end else begin
            state <= state_n;
            if (we && a == 3'd0) opa <= wd;
            if (we && a == 3'd1) opb <= wd;
            if (we && a == 3'd2) begin
                op     <= wd[1];
                irq_en <= wd[2];
            end
            if (accept) begin
                core_a  <= opa;
                core_b  <= opb;
                core_op <= wd[1];
            end
            if (start_req && !accept) drop_err <= 1'b1;
            else if (we && a == 3'd3 && wd[8]) drop_err <= 1'b0;
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    // Result storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_p[wp] <= core_p;
            mem_f[wp] <= core_flags;
        end
    end
    // STATUS word assembly.
    always_comb begin
        status               = '0;
        status[0]            = busy;
        status[1]            = empty;
        status[2]            = full;
        status[8]            = drop_err;
        status[16 +: CNT_W]  = count;
    end
    // Register read mux; RESULT and FLAGS read zero when nothing is queued.
    always_comb begin
        rd = '0;
        case (a)
            3'd0:    rd = opa;
            3'd1:    rd = opb;
            3'd2:    rd = {{(DATA_W-3){1'b0}}, irq_en, op, 1'b0};
            3'd3:    rd = status;
            3'd4:    rd = empty ? '0 : head_p;
            3'd5:    rd = empty ? '0 : {{(DATA_W-FLAG_W){1'b0}}, head_f};
            default: rd = '0;
        endcase
    end
endmodule

// File: tb/tb_fpu_mmio_queue.sv
// tb_fpu_mmio_queue: directed self-checking bench with a hand-driven FP core.
module tb_fpu_mmio_queue;
    logic clk = 0, rst = 1, we = 0, core_done = 0;
    logic [2:0] a = 0;
    logic [31:0] wd = 0, core_p = 0, rd, core_a, core_b;
    logic [5:0] core_flags = 0;
    logic irq, invalid, overflow, core_start, core_op;
    int passed = 0, total = 0;

    fpu_mmio_queue dut (
        .clk(clk), .rst(rst), .a(a), .wd(wd), .we(we), .rd(rd), .irq(irq),
        .invalid(invalid), .overflow(overflow), .core_start(core_start),
        .core_op(core_op), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_p(core_p), .core_flags(core_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic [5:0]  f;
        logic        op;
        logic        inv;
        logic        ovf;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] ad, input logic [31:0] d);
        a = ad; wd = d; we = 1;
        tick();
        we = 0;
    endtask

    task automatic rdc(input string n, input logic [2:0] ad, input logic [31:0] e);
        a = ad;
        #1;
        chk(n, rd, e);
    endtask

    task automatic done_pulse(input logic [31:0] p, input logic [5:0] f);
        core_p = p; core_flags = f; core_done = 1;
        tick();
        core_done = 0;
    endtask

    task automatic job(input logic [31:0] p, input logic [5:0] f);
        wr(2, 32'h5);
        tick();
        done_pulse(p, f);
    endtask

    initial begin
        tbl[0] = '{32'h11, 6'h20, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{32'h12, 6'h01, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{32'h13, 6'h04, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{32'h14, 6'h02, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{32'h15, 6'h10, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{32'h16, 6'h08, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{32'h17, 6'h00, 1'b0, 1'b0, 1'b0};

        repeat (2) tick();
        rst = 0;
        tick();
        rdc("reset_status", 3, 32'h2);
        rdc("reset_result", 4, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_core_a", core_a, 32'h0);
        chk("reset_start", {31'b0, core_start}, 32'h0);
        rdc("reg6_zero", 6, 32'h0);

        wr(0, 32'h3FC00000);
        wr(1, 32'h40000000);
        wr(2, 32'h5);
        chk("basic_start", {31'b0, core_start}, 32'h1);
        chk("basic_core_a", core_a, 32'h3FC00000);
        chk("basic_core_b", core_b, 32'h40000000);
        chk("basic_core_op", {31'b0, core_op}, 32'h0);
        rdc("basic_busy", 3, 32'h3);
        rdc("ctrl_readback", 2, 32'h4);
        tick();
        chk("basic_start_one_cycle", {31'b0, core_start}, 32'h0);
        tick();
        done_pulse(32'h40400000, 6'h00);
        rdc("basic_result", 4, 32'h40400000);
        rdc("basic_status", 3, 32'h00010000);
        chk("basic_irq", {31'b0, irq}, 32'h1);
        wr(4, 32'h0);
        chk("basic_pop_irq", {31'b0, irq}, 32'h0);
        rdc("basic_pop_status", 3, 32'h2);

        for (int i = 0; i < 7; i++) begin
            wr(2, tbl[i].op ? 32'h7 : 32'h5);
            chk($sformatf("tbl%0d_op", i), {31'b0, core_op}, {31'b0, tbl[i].op});
            tick();
            done_pulse(tbl[i].p, tbl[i].f);
            rdc($sformatf("tbl%0d_result", i), 4, tbl[i].p);
            rdc($sformatf("tbl%0d_flags", i), 5, {26'b0, tbl[i].f});
            chk($sformatf("tbl%0d_invalid", i), {31'b0, invalid}, {31'b0, tbl[i].inv});
            chk($sformatf("tbl%0d_overflow", i), {31'b0, overflow}, {31'b0, tbl[i].ovf});
            wr(4, 32'h0);
            chk($sformatf("tbl%0d_pop_flags", i), {30'b0, invalid, overflow}, 32'h0);
        end

        for (int i = 0; i < 4; i++) job(32'h100 + i, 6'(i));
        rdc("full_status", 3, 32'h00040004);
        wr(2, 32'h3);
        chk("full_no_start", {31'b0, core_start}, 32'h0);
        rdc("full_drop", 3, 32'h00040104);
        rdc("full_ctrl_updates", 2, 32'h2);
        chk("full_irq_off", {31'b0, irq}, 32'h0);
        wr(3, 32'h100);
        rdc("drop_clear", 3, 32'h00040004);
        wr(2, 32'h4);
        chk("irq_back_on", {31'b0, irq}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            rdc($sformatf("fifo_order%0d", i), 4, 32'h100 + i);
            wr(4, 32'h0);
        end
        rdc("drained", 3, 32'h2);

        done_pulse(32'hDEAD, 6'h0);
        rdc("idle_done_ignored", 3, 32'h2);

        wr(0, 32'hAAAA);
        wr(2, 32'h5);
        chk("busy_start", {31'b0, core_start}, 32'h1);
        wr(0, 32'h1234);
        wr(2, 32'h5);
        rdc("busy_drop", 3, 32'h00000103);
        rdc("opa_overwritten", 0, 32'h1234);
        chk("inflight_core_a", core_a, 32'hAAAA);
        repeat (7) tick();
        done_pulse(32'h55, 6'h0);
        repeat (3) tick();
        rdc("one_push", 3, 32'h00010100);
        wr(3, 32'h100);
        wr(4, 32'h0);
        rdc("busy_cleanup", 3, 32'h2);

        job(32'h21, 6'h0);
        job(32'h22, 6'h0);
        wr(2, 32'h5);
        tick();
        a = 4; we = 1; core_p = 32'h23; core_flags = 6'h0; core_done = 1;
        tick();
        we = 0; core_done = 0;
        rdc("pushpop_count", 3, 32'h00020000);
        rdc("pushpop_head", 4, 32'h22);
        wr(4, 32'h0);
        rdc("pushpop_tail", 4, 32'h23);
        wr(4, 32'h0);
        wr(4, 32'h0);
        rdc("pop_empty_no_underflow", 3, 32'h2);

        wr(2, 32'h5);
        tick();
        a = 4; we = 1; core_p = 32'h31; core_flags = 6'h0; core_done = 1;
        tick();
        we = 0; core_done = 0;
        rdc("pushpop_empty", 3, 32'h00010000);
        wr(4, 32'h0);

        wr(2, 32'h5);
        tick();
        rst = 1;
        #1;
        rdc("rst_mid_job", 3, 32'h2);
        tick();
        rst = 0;
        done_pulse(32'h77, 6'h0);
        rdc("late_done_ignored", 3, 32'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fpu_mmio_queue.md
Name: fpu_mmio_queue

Overview:
- Parametrised successor to the single-shot FP multiplier MMIO wrapper.
- Sits on the CPU memory-mapped bus.
- Latches operands and an op-select, and drives a generic start/done FP core port, so the same wrapper serves the multiplier, the adder or a combined unit.
- Buffers results plus flags in a DEPTH-entry FIFO, so software can queue several jobs, read results later and take a level interrupt.

Parameters:
- DATA_W, 32: operand/result width.
- FLAG_W, 6: core flag width, ordered {OF,UF,NaNF,InfF,DNF,ZF} at bits [5:0].
- DEPTH, 4: result FIFO entries; power of two, 2..128.
- CNT_W, $clog2(DEPTH+1): occupancy counter width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  3  register address (word index).
- wd  in  DATA_W  write data.
- we  in  1  bus write enable.
- rd  out  DATA_W  read data (combinational mux).
- irq  out  1  = irq_en & ~empty.
- invalid  out  1  = ~empty & (head DNF|ZF|UF).
- overflow  out  1  = ~empty & (head OF|InfF).
- core_start  out  1  one-cycle start pulse to the FP core.
- core_op  out  1  op select latched at issue (0=mul, 1=add).
- core_a  out  DATA_W  operand A snapshot.
- core_b  out  DATA_W  operand B snapshot.
- core_done  in  1  one-cycle completion pulse from the core.
- core_p  in  DATA_W  core result, valid with core_done.
- core_flags  in  FLAG_W  core flags, valid with core_done.

Behaviour:
- Register map (by a):
  - 0 OPA: R/W.
  - 1 OPB: R/W.
  - 2 CTRL: write bit0=start (self-clearing, reads 0), bit1=op, bit2=irq_en; bits 2:1 read back.
  - 3 STATUS: read-only except bit8.
    - bit0 busy, bit1 empty, bit2 full, bit8 drop_err (sticky), bits[16+CNT_W-1:16] count; other bits 0.
    - Writing STATUS with wd[8]=1 clears drop_err.
  - 4 RESULT: read returns head result, or 0 when empty; any write pops.
  - 5 FLAGS: read returns head flags zero-extended, or 0 when empty.
  - 6, 7: read 0, writes ignored.
- Reset values:
  - All registers 0, FIFO empty, count 0, state IDLE.
  - Outputs: core_start=0, irq=0, invalid=0, overflow=0; core_a/core_b/core_op 0.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE on a CTRL write with wd[0]=1 and ~full. At that edge, OPA, OPB and op are snapshotted into core_a, core_b and core_op.
  - ISSUE: core_start=1 for exactly this cycle. Next state is WAIT, or IDLE if core_done is already high.
  - WAIT -> IDLE on core_done.
  - core_done is sampled only in ISSUE or WAIT. In IDLE it is ignored: no push, no state change.
  - busy = (state != IDLE).
- Latency:
  - Start written in cycle T gives core_start high in T+1.
  - core_done in cycle D pushes {core_p, core_flags} at the end of D. RESULT, irq, count and busy=0 are all visible in D+1.
- Dropped starts: a start while busy or full is dropped. It sets drop_err, leaves the FIFO and snapshot untouched, and the FSM is unchanged. The op/irq_en bits of that same write still update.
- Overwriting operands: OPA/OPB writes while busy are allowed and do not affect the in-flight job.
- FIFO pointers:
  - log2(DEPTH)-bit read and write pointers wrap naturally.
  - count is tracked separately, 0..DEPTH.
  - full = (count==DEPTH), empty = (count==0).
- Push and pop in the same cycle:
  - When not empty, both occur and count is unchanged.
  - When empty, the push occurs and the pop is ignored.
  - Pop on empty is ignored; count never underflows.
- No push can occur on full, because start is refused on full and only one job is ever in flight.
- rst asserted mid-job returns the block to IDLE immediately. A core_done arriving after rst release is ignored because the state is IDLE.
- irq, invalid and overflow are level outputs tracking the FIFO head. They drop the cycle after the pop that empties the FIFO.

Test Plan:
- Reset, then read STATUS -> 0x00000002 (empty=1, all other fields 0); rd on RESULT = 0; irq=0.
- OPA=0x3FC00000, OPB=0x40000000, CTRL=0x5 (start, mul, irq_en); bench core returns 0x40400000, flags 0, after 3 cycles:
  - core_start pulses one cycle after the write, with core_a=0x3FC00000, core_op=0.
  - One cycle after core_done: RESULT=0x40400000, STATUS count=1, irq=1.
  - Write RESULT -> empty, irq=0.
- Queue DEPTH=4 jobs without popping -> full=1, count=4. A fifth start -> no core_start, drop_err=1. STATUS write 0x100 -> drop_err=0.
- Start while busy (core held 10 cycles) -> ignored, drop_err=1. Overwrite OPA mid-job -> core_a unchanged. Exactly one push.
- Core returns flags 0x20 (OF) -> overflow=1, FLAGS reads 0x20. Flags 0x01 (ZF) -> invalid=1. Pop clears both.
- With count=2, core_done coincides with a RESULT pop -> count stays 2 and the head advances. Assert rst during WAIT then pulse core_done -> no push, STATUS=0x2.
